// File: rtl/veerwolf_uart_pkg.sv
// -----------------------------------------------------------------------------
// veerwolf_uart_pkg
// Shared types and helpers for the bench-side UART stimulus transmitter.
//   tx_state_t      : transmitter FSM states
//   UART_DATA_BITS  : data bits per frame
//   UART_IDLE_LEVEL : level of the serial line when nothing is being sent
//   frame_len()     : bit periods per frame (10 for 8N1, 11 for 8E1)
//   even_parity()   : even-parity bit over one data byte
// -----------------------------------------------------------------------------
package veerwolf_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    function automatic int unsigned frame_len(input logic parity_en);
        if (parity_en) begin
            return 32'd11;
        end else begin
            return 32'd10;
        end
    endfunction

    // XOR of all data bits makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/veerwolf_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// veerwolf_uart_tx_fifo
// Synchronous byte FIFO feeding the UART transmitter.
// Ports:
//   clk, rstn  : clock and asynchronous active-low reset
//   push_i     : write data_i (ignored while full)
//   data_i     : byte to store
//   pop_i      : discard the head entry (ignored while empty)
//   data_o     : head entry (valid while !empty_o)
//   full_o     : level_o == FIFO_DEPTH
//   empty_o    : level_o == 0
//   level_o    : occupancy, 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module veerwolf_uart_tx_fifo
    import veerwolf_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      push_i,
    input  logic [UART_DATA_BITS-1:0] data_i,
    input  logic                      pop_i,
    output logic [UART_DATA_BITS-1:0] data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [AW:0]               level_o
);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   lvl_t;

    localparam lvl_t DEPTH_LVL = lvl_t'(FIFO_DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    ptr_t wr_ptr_q;
    ptr_t rd_ptr_q;
    lvl_t level_q;
    logic do_push_s;
    logic do_pop_s;

    assign full_o    = (level_q == DEPTH_LVL);
    assign empty_o   = (level_q == lvl_t'(0));
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // Pointer and occupancy tracking; simultaneous push and pop keep the level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= ptr_t'(0);
            rd_ptr_q <= ptr_t'(0);
            level_q  <= lvl_t'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_q <= level_q + lvl_t'(1);
                2'b01:   level_q <= level_q - lvl_t'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/veerwolf_uart_stim_tx.sv
// -----------------------------------------------------------------------------
// veerwolf_uart_stim_tx
// Bench-side UART transmitter driving the SoC console receive line.
// Bytes enter through a valid/ready port into a FIFO and are sent LSB first
// as 8N1 frames, DIVISOR clocks per bit, with no gap between queued frames.
// Optional feature: define VEERWOLF_UART_TX_PARITY_EN to insert an even-parity
// bit between data bit 7 and the stop bit (8E1, 11 bit periods per frame).
// Ports:
//   clk, rstn  : clock and asynchronous active-low reset
//   i_data     : byte to transmit
//   i_valid    : i_data is valid; accepted on a clock edge with o_ready high
//   o_ready    : FIFO has room
//   o_uart_tx  : registered serial line, idle high
//   o_busy     : a frame is in progress or bytes are queued
//   o_level    : FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module veerwolf_uart_stim_tx
    import veerwolf_uart_pkg::*;
#(
    parameter int DIVISOR    = 868,
    parameter int FIFO_DEPTH = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_uart_tx,
    output logic        o_busy,
    output logic [AW:0] o_level
);

    typedef logic [15:0] cnt_t;

    localparam cnt_t       BAUD_RELOAD = cnt_t'(DIVISOR - 1);
    localparam logic [2:0] LAST_BIT    = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state_q;
    tx_state_t                 state_d;
    cnt_t                      cnt_q;
    cnt_t                      cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic [2:0]                idx_q;
    logic [2:0]                idx_d;
`ifdef VEERWOLF_UART_TX_PARITY_EN
    logic                      par_q;
    logic                      par_d;
`endif
    logic                      tx_q;
    logic                      busy_q;

    logic                      line_s;
    logic                      push_s;
    logic                      pop_s;
    logic [UART_DATA_BITS-1:0] fifo_data_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;

    assign o_ready   = !fifo_full_s;
    assign push_s    = i_valid && o_ready;
    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;

    veerwolf_uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_s),
        .data_i  (i_data),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (o_level)
    );

    // Frame sequencing: next state, baud counter, shifter and line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef VEERWOLF_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        pop_s   = 1'b0;
        line_s  = UART_IDLE_LEVEL;

        case (state_q)
            ST_IDLE: begin
                line_s = UART_IDLE_LEVEL;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_data_s;
`ifdef VEERWOLF_UART_TX_PARITY_EN
                    par_d   = even_parity(fifo_data_s);
`endif
                    cnt_d   = BAUD_RELOAD;
                    state_d = ST_START;
                end else begin
                    cnt_d   = cnt_t'(0);
                end
            end

            ST_START: begin
                line_s = 1'b0;
                if (cnt_q == cnt_t'(0)) begin
                    cnt_d   = BAUD_RELOAD;
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                end
            end

            ST_DATA: begin
                line_s = shift_q[0];
                if (cnt_q == cnt_t'(0)) begin
                    cnt_d   = BAUD_RELOAD;
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_BIT) begin
`ifdef VEERWOLF_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                end
            end

`ifdef VEERWOLF_UART_TX_PARITY_EN
            ST_PARITY: begin
                line_s = par_q;
                if (cnt_q == cnt_t'(0)) begin
                    cnt_d   = BAUD_RELOAD;
                    state_d = ST_STOP;
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                end
            end
`endif

            ST_STOP: begin
                line_s = UART_IDLE_LEVEL;
                if (cnt_q == cnt_t'(0)) begin
                    // A queued byte starts immediately so frames run back to back.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_data_s;
`ifdef VEERWOLF_UART_TX_PARITY_EN
                        par_d   = even_parity(fifo_data_s);
`endif
                        cnt_d   = BAUD_RELOAD;
                        state_d = ST_START;
                    end else begin
                        cnt_d   = cnt_t'(0);
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q - cnt_t'(1);
                end
            end

            default: begin
                line_s  = UART_IDLE_LEVEL;
                cnt_d   = cnt_t'(0);
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; the line and busy flag are registered from the current
    // state, so both trail the FSM by one clock and stay aligned with each other.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= cnt_t'(0);
            shift_q <= {UART_DATA_BITS{1'b0}};
            idx_q   <= 3'd0;
`ifdef VEERWOLF_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
            tx_q    <= UART_IDLE_LEVEL;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
`ifdef VEERWOLF_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
            tx_q    <= line_s;
            busy_q  <= (state_q != ST_IDLE) || !fifo_empty_s;
        end
    end

endmodule
